// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO input debounce block.
//   BUS_DW      - width of the register read/write data bus.
//   gpio_reg_e  - word addresses of the register map.
package gpio_pkg;

    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        GPIO_REG_DATA   = 2'd0,
        GPIO_REG_CHANGE = 2'd1,
        GPIO_REG_MASK   = 2'd2,
        GPIO_REG_RSVD   = 2'd3
    } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: one GPIO input bit -- two-flop synchronizer, stability
// counter and debounced level flop.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   pin       - raw asynchronous pin level
//   level     - debounced level (registered)
//   rise_fall - high during the cycle whose closing edge accepts a new level;
//               derived from registers only
module gpio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise_fall
);

    // One spare bit so the terminal count is always representable.
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          accept_s;

    // Acceptance condition: synchronized level differs and has been stable long enough.
    always_comb begin
        accept_s = 1'b0;
        if ((sync2_r != level_r) && (cnt_r == TERM)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Synchronizer, stability counter and debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= RESET_BIT;
            sync2_r <= RESET_BIT;
            level_r <= RESET_BIT;
            cnt_r   <= CW'(0);
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= CW'(0);
            end else if (cnt_r == TERM) begin
                level_r <= sync2_r;
                cnt_r   <= CW'(0);
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level     = level_r;
    assign rise_fall = accept_s;

endmodule

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: synchronizes and debounces raw GPIO input pins, latches
// per-bit change events and exposes them through a word-addressed register
// interface with a level interrupt.
// Ports:
//   clk, rst      - system clock / synchronous active-high reset
//   gpio_pins_i   - raw pin levels (WIDTH)
//   gpio_o        - debounced value, feeds the core GPIO input (WIDTH)
//   bus_addr      - register select: 0 DATA, 1 CHANGE (W1C), 2 MASK, 3 reserved
//   bus_we        - one-cycle write strobe
//   bus_wdata     - write data (32)
//   bus_rdata     - registered read data, one-cycle latency (32)
//   irq_o         - high while any unmasked change flag is set
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  gpio_pins_i,
    output logic [WIDTH-1:0]  gpio_o,
    input  logic [1:0]        bus_addr,
    input  logic              bus_we,
    input  logic [BUS_DW-1:0] bus_wdata,
    output logic [BUS_DW-1:0] bus_rdata,
    output logic              irq_o
);

    logic [WIDTH-1:0]  debounced_s;
    logic [WIDTH-1:0]  accept_s;
    logic [WIDTH-1:0]  change_r;
    logic [WIDTH-1:0]  mask_r;
    logic [BUS_DW-1:0] rdata_r;
    logic [WIDTH-1:0]  change_next_s;
    logic [WIDTH-1:0]  mask_next_s;
    logic [BUS_DW-1:0] rdata_next_s;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VALUE[gi])
            ) u_bit (
                .clk       (clk),
                .rst       (rst),
                .pin       (gpio_pins_i[gi]),
                .level     (debounced_s[gi]),
                .rise_fall (accept_s[gi])
            );
        end

        // Write-data bits above WIDTH have no storage behind them.
        if (WIDTH < BUS_DW) begin : g_unused
            logic unused_wdata_s;
            assign unused_wdata_s = &{1'b0, bus_wdata[BUS_DW-1:WIDTH]};
        end
    endgenerate

    // W1C clear first, then new events OR'd in so a same-edge set wins.
    always_comb begin
        change_next_s = change_r;
        if (bus_we && (bus_addr == GPIO_REG_CHANGE)) begin
            change_next_s = change_r & ~bus_wdata[WIDTH-1:0];
        end else begin
            change_next_s = change_r;
        end
        change_next_s = change_next_s | accept_s;
    end

    // Mask register write.
    always_comb begin
        mask_next_s = mask_r;
        if (bus_we && (bus_addr == GPIO_REG_MASK)) begin
            mask_next_s = bus_wdata[WIDTH-1:0];
        end else begin
            mask_next_s = mask_r;
        end
    end

    // Read mux over pre-update register state; unused upper bits stay zero.
    always_comb begin
        rdata_next_s = {BUS_DW{1'b0}};
        case (gpio_reg_e'(bus_addr))
            GPIO_REG_DATA:   rdata_next_s[WIDTH-1:0] = debounced_s;
            GPIO_REG_CHANGE: rdata_next_s[WIDTH-1:0] = change_r;
            GPIO_REG_MASK:   rdata_next_s[WIDTH-1:0] = mask_r;
            default:         rdata_next_s = {BUS_DW{1'b0}};
        endcase
    end

    // Register-file state and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            change_r <= {WIDTH{1'b0}};
            mask_r   <= {WIDTH{1'b0}};
            rdata_r  <= {BUS_DW{1'b0}};
        end else begin
            change_r <= change_next_s;
            mask_r   <= mask_next_s;
            rdata_r  <= rdata_next_s;
        end
    end

    assign gpio_o    = debounced_s;
    assign bus_rdata = rdata_r;
    // Purely from registers: no combinational path from the bus.
    assign irq_o     = |(change_r & mask_r);

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce: directed self-checking bench for gpio_in_debounce
// (WIDTH=8, DEBOUNCE_CYCLES=4, RESET_VALUE=0). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_gpio_in_debounce;

    logic        clk;
    logic        rst;
    logic [7:0]  gpio_pins_i;
    logic [7:0]  gpio_o;
    logic [1:0]  bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq_o;

    int tests_run;
    int tests_failed;

    gpio_in_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_pins_i (gpio_pins_i),
        .gpio_o      (gpio_o),
        .bus_addr    (bus_addr),
        .bus_we      (bus_we),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        tick(1);
        bus_we    = 1'b0;
        bus_wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        tick(1);
        d = bus_rdata;
    endtask

    logic [31:0] rd;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        gpio_pins_i  = 8'hFF;
        bus_addr     = 2'd0;
        bus_we       = 1'b0;
        bus_wdata    = 32'h0;

        // Reset held for two edges with all pins high.
        tick(2);
        check("rst_gpio",  {24'h0, gpio_o}, 32'h0);
        check("rst_irq",   {31'h0, irq_o},  32'h0);
        check("rst_rdata", bus_rdata,       32'h0);
        rst = 1'b0;

        // First edge after release: DATA still 0; value lands on edge 6.
        bus_read(2'd0, rd);
        check("data_after_rel", rd, 32'h0);
        tick(4);
        check("gpio_edge5", {24'h0, gpio_o}, 32'h00);
        tick(1);
        check("gpio_edge6", {24'h0, gpio_o}, 32'hFF);
        bus_read(2'd1, rd);
        check("change_ff", rd, 32'hFF);
        check("irq_masked", {31'h0, irq_o}, 32'h0);
        bus_write(2'd1, 32'hFF);
        bus_read(2'd1, rd);
        check("change_clr", rd, 32'h0);

        // Return all pins low and clear the resulting flags.
        gpio_pins_i = 8'h00;
        tick(8);
        check("gpio_low", {24'h0, gpio_o}, 32'h00);
        bus_write(2'd1, 32'hFF);

        // 3-cycle glitch must be rejected.
        gpio_pins_i = 8'h01;
        tick(3);
        gpio_pins_i = 8'h00;
        tick(8);
        check("glitch_gpio", {24'h0, gpio_o}, 32'h00);
        bus_read(2'd1, rd);
        check("glitch_change", rd, 32'h0);

        // 4-cycle pulse propagates.
        gpio_pins_i = 8'h01;
        tick(4);
        gpio_pins_i = 8'h00;
        tick(2);
        check("pulse_gpio", {24'h0, gpio_o}, 32'h01);
        tick(8);
        check("pulse_gpio_back", {24'h0, gpio_o}, 32'h00);
        bus_read(2'd1, rd);
        check("pulse_change", rd, 32'h01);
        bus_write(2'd1, 32'hFF);

        // Interrupt masking and W1C.
        bus_write(2'd2, 32'h0F);
        gpio_pins_i = 8'h10;
        tick(8);
        bus_read(2'd1, rd);
        check("irq_change10", rd, 32'h10);
        check("irq_bit4_masked", {31'h0, irq_o}, 32'h0);
        gpio_pins_i = 8'h11;
        tick(8);
        check("irq_bit0", {31'h0, irq_o}, 32'h1);
        bus_write(2'd1, 32'h01);
        check("irq_cleared", {31'h0, irq_o}, 32'h0);
        bus_read(2'd1, rd);
        check("change_after_w1c", rd, 32'h10);
        bus_write(2'd1, 32'hFF);

        // Set-wins: W1C of bit2 on the accepting edge (6th edge after the change).
        gpio_pins_i = 8'h15;
        tick(5);
        bus_write(2'd1, 32'h04);
        check("collide_gpio", {24'h0, gpio_o}, 32'h15);
        bus_read(2'd1, rd);
        check("collide_change", rd, 32'h04);
        check("collide_irq", {31'h0, irq_o}, 32'h1);
        bus_write(2'd1, 32'hFF);

        // Reset mid-debounce at count 2.
        gpio_pins_i = 8'h35;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_gpio", {24'h0, gpio_o}, 32'h00);
        check("midrst_irq",  {31'h0, irq_o},  32'h0);
        bus_read(2'd1, rd);
        check("midrst_change", rd, 32'h0);
        tick(4);
        check("reaccept_edge5", {24'h0, gpio_o}, 32'h00);
        tick(1);
        check("reaccept_edge6", {24'h0, gpio_o}, 32'h35);

        // Bus map behaviour.
        bus_read(2'd0, rd);
        check("rd_data", rd, 32'h35);
        bus_read(2'd2, rd);
        check("rd_mask_rst", rd, 32'h0);
        bus_read(2'd1, rd);
        check("rd_change", rd, 32'h35);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, rd);
        check("rd_mask_ff", rd, 32'h0000_00FF);
        check("irq_all", {31'h0, irq_o}, 32'h1);
        bus_write(2'd0, 32'h0000_0000);
        bus_read(2'd0, rd);
        check("data_ro", rd, 32'h35);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3, rd);
        check("rsvd_zero", rd, 32'h0);
        bus_read(2'd2, rd);
        check("mask_kept", rd, 32'h0000_00FF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
